gate_bist_ctrl: RTL and testbench

//   Self-test sequencer for a small combinational gate (AND/OR/XOR/...). On start it

---
 rtl/gate_bist_pkg.sv | 18 +
 rtl/gate_bist_if.sv | 24 ++
 rtl/gate_bist_settle_cnt.sv | 37 +++
 rtl/gate_bist_ctrl.sv | 126 ++++++++++++
 tb/tb_gate_bist_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate self-test sequencer.
// Truth tables are indexed by input vector: bit i is the expected output for input i.
package gate_bist_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StWait  = 2'd1;
  localparam state_t StCheck = 2'd2;
  localparam state_t StDone  = 2'd3;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/gate_bist_if.sv
// Control, status and gate-facing signals of the self-test sequencer.
// master drives start and the gate output; slave is the sequencer.
interface gate_bist_if #(
  parameter int unsigned N_IN = 2
);
  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] fail_vec;

  modport master (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_bist_settle_cnt.sv
// Loadable down-counter timing the settle interval after each applied vector.
// Saturates at zero; zero_o flags that the wait is over.
module gate_bist_settle_cnt #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  // Keep at least one bit so SETTLE=0 still builds.
  localparam int unsigned CntW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(SETTLE);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer: walks every input vector through a combinational gate, compares
// its output against TRUTH and reports verdict, mismatch count and first failing vector.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned        N_IN   = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = 4'b1000,
  parameter int unsigned        SETTLE = 2
) (
  input logic       clk,
  input logic       rst,
  gate_bist_if.slave bus
);

  localparam logic [N_IN-1:0] LastIdx = '1;

  state_t          state_d, state_q;
  logic [N_IN-1:0] idx_d, idx_q;
  logic [N_IN-1:0] dut_in_d, dut_in_q;
  logic            busy_d, busy_q;
  logic            done_d, done_q;
  logic            pass_d, pass_q;
  logic [N_IN:0]   err_d, err_q;
  logic [N_IN-1:0] fail_d, fail_q;

  logic            cnt_load, cnt_dec, cnt_zero;
  logic            mism;
  logic [N_IN:0]   err_inc;

  gate_bist_settle_cnt #(
    .SETTLE(SETTLE)
  ) u_settle_cnt (
    .clk   (clk),
    .rst   (rst),
    .load_i(cnt_load),
    .dec_i (cnt_dec),
    .zero_o(cnt_zero)
  );

  // Case inequality so an X/Z gate output is never mistaken for a match.
  assign mism    = (bus.dut_out !== TRUTH[idx_q]);
  assign err_inc = err_q + (N_IN+1)'(mism);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dut_in_d = dut_in_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          idx_d    = '0;
          dut_in_d = '0;
          err_d    = '0;
          fail_d   = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (cnt_zero) begin
          state_d = StCheck;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StCheck: begin
        err_d = err_inc;
        if (mism && (err_q == '0)) begin
          fail_d = idx_q;
        end
        if (idx_q == LastIdx) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_inc == '0);
          state_d = StDone;
        end else begin
          idx_d    = idx_q + N_IN'(1);
          dut_in_d = idx_q + N_IN'(1);
          cnt_load = 1'b1;
          state_d  = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: table-driven full runs against modelled gates plus
// hand-written sequences for held start, async reset and a 3-input configuration.
module tb_gate_bist_ctrl;
  import gate_bist_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;  // 0 = AND gate, 1 = OR gate, 2 = AND gate with X on vector 11
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  gate_bist_if #(.N_IN(2)) bif ();
  gate_bist_if #(.N_IN(3)) bif3 ();

  assign bif.dut_out  = (mode == 2 && bif.dut_in == 2'b11) ? 1'bx :
                        (mode == 1) ? |bif.dut_in : &bif.dut_in;
  assign bif3.dut_out = &bif3.dut_in;

  gate_bist_ctrl #(
    .N_IN  (2),
    .TRUTH (TT_AND),
    .SETTLE(2)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  gate_bist_ctrl #(
    .N_IN  (3),
    .TRUTH (8'h80),
    .SETTLE(0)
  ) u_dut3 (
    .clk(clk),
    .rst(rst),
    .bus(bif3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start a run on u_dut (edge 0) and return the edge index at which done is seen.
  task automatic run_std(input logic hold, output int done_edge);
    done_edge = -1;
    @(negedge clk);
    bif.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bif.start = 1'b0;
    check("busy_e0", 32'(bif.busy), 32'd1);
    check("din_e0", 32'(bif.dut_in), 32'd0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bif.done) begin
        done_edge = k;
        break;
      end
      if (k < 16) begin
        check("din_seq", 32'(bif.dut_in), 32'(k / 4));
        check("busy_seq", 32'(bif.busy), 32'd1);
      end
    end
  endtask

  typedef struct {
    string      name;
    int         mode;
    logic       exp_pass;
    int         exp_err;
    int         exp_fail;
  } row_t;

  row_t tbl[3];
  int   de;

  initial begin
    tbl[0] = '{name: "and_ok",  mode: 0, exp_pass: 1'b1, exp_err: 0, exp_fail: 0};
    tbl[1] = '{name: "or_gate", mode: 1, exp_pass: 1'b0, exp_err: 2, exp_fail: 1};
    tbl[2] = '{name: "x_on_11", mode: 2, exp_pass: 1'b0, exp_err: 1, exp_fail: 3};

    bif.start  = 1'b0;
    bif3.start = 1'b0;
    #12;
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);
    check("rst_pass", 32'(bif.pass), 32'd0);
    check("rst_err", 32'(bif.err_count), 32'd0);
    check("rst_fail", 32'(bif.fail_vec), 32'd0);
    check("rst_din", 32'(bif.dut_in), 32'd0);
    check("rst_din3", 32'(bif3.dut_in), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      run_std(1'b0, de);
      check({tbl[i].name, "_done_edge"}, 32'(de), 32'd16);
      check({tbl[i].name, "_pass"}, 32'(bif.pass), 32'(tbl[i].exp_pass));
      check({tbl[i].name, "_err"}, 32'(bif.err_count), 32'(tbl[i].exp_err));
      check({tbl[i].name, "_fail"}, 32'(bif.fail_vec), 32'(tbl[i].exp_fail));
      check({tbl[i].name, "_busy"}, 32'(bif.busy), 32'd0);
      check({tbl[i].name, "_din"}, 32'(bif.dut_in), 32'd3);
      @(posedge clk);
      #1;
      check({tbl[i].name, "_done_hold"}, 32'(bif.done), 32'd1);
    end

    // Start held high: ignored while busy, restarts from DONE with counts cleared.
    mode = 1;
    run_std(1'b1, de);
    check("hold_done_edge", 32'(de), 32'd16);
    check("hold_err", 32'(bif.err_count), 32'd2);
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    check("restart_done", 32'(bif.done), 32'd0);
    check("restart_busy", 32'(bif.busy), 32'd1);
    check("restart_err", 32'(bif.err_count), 32'd0);
    check("restart_din", 32'(bif.dut_in), 32'd0);
    de = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bif.done) begin
        de = k;
        break;
      end
    end
    check("restart_done_edge", 32'(de), 32'd16);

    // Async reset in the middle of vector 2's settle wait.
    mode = 0;
    @(negedge clk);
    bif.start = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_din", 32'(bif.dut_in), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(bif.busy), 32'd0);
    check("arst_din", 32'(bif.dut_in), 32'd0);
    check("arst_done", 32'(bif.done), 32'd0);
    check("arst_err", 32'(bif.err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_resume_busy", 32'(bif.busy), 32'd0);
    run_std(1'b0, de);
    check("post_rst_done_edge", 32'(de), 32'd16);
    check("post_rst_pass", 32'(bif.pass), 32'd1);
    check("post_rst_err", 32'(bif.err_count), 32'd0);

    // 3-input AND with no settle wait.
    @(negedge clk);
    bif3.start = 1'b1;
    @(posedge clk);
    #1;
    bif3.start = 1'b0;
    de = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bif3.done) begin
        de = k;
        break;
      end
    end
    check("n3_done_edge", 32'(de), 32'd16);
    check("n3_pass", 32'(bif3.pass), 32'd1);
    check("n3_err", 32'(bif3.err_count), 32'd0);
    check("n3_din", 32'(bif3.dut_in), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
